fixed_quant_pack: RTL and testbench

//  Post-multiply quantiser stage; sits directly downstream of the pipelined Booth multiplier.
//  - Takes the full-width signed product stream (DCT coeff x reciprocal quant step, Q.FRAC).
//  - Rounds half-away-from-zero, saturates to OUT_WIDTH and tags 8x8 block boundaries.
//  - Buffers results in a small FIFO for the valid/ready entropy-coder interface.
//  - Upstream has no backpressure, so FIFO overflow is flagged, never stalled.

---
 rtl/jpeg_quant_pkg.sv | 17 +
 rtl/quant_fifo.sv | 41 ++++
 rtl/fixed_quant_pack.sv | 103 ++++++++++
 tb/tb_fixed_quant_pack.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_quant_pkg.sv
// Shared types for the post-multiply quantiser: coefficient type, FIFO entry and clip limits.
package jpeg_quant_pkg;

  localparam int unsigned OUT_WIDTH = 12;

  typedef logic signed [OUT_WIDTH-1:0] coeff_t;

  typedef struct packed {
    coeff_t c;
    logic   sat;
    logic   last;
  } qentry_t;

  localparam coeff_t COEFF_MAX = coeff_t'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam coeff_t COEFF_MIN = coeff_t'({1'b1, {(OUT_WIDTH-1){1'b0}}});

endpackage

// File: rtl/quant_fifo.sv
// Synchronous FIFO of quantised entries; extra-bit pointers distinguish full from empty.
module quant_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  jpeg_quant_pkg::qentry_t wr_data,
  output logic                    full,
  input  logic                    rd_en,
  output jpeg_quant_pkg::qentry_t rd_data,
  output logic                    empty
);
  import jpeg_quant_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wp;
  logic [AW:0] rp;
  qentry_t     mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (rd_en) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end

  // When full, the write slot equals the read slot; the head is read before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= wr_data;
  end

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = mem[rp[AW-1:0]];

endmodule

// File: rtl/fixed_quant_pack.sv
// Post-multiply quantiser: round half-away-from-zero, saturate, tag block ends, buffer in a FIFO.
module fixed_quant_pack #(
  parameter int unsigned IN_WIDTH   = 52,
  parameter int unsigned FRAC       = 16,
  parameter int unsigned OUT_WIDTH  = 12,
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  din,
  input  logic                        din_valid,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        dout_sat,
  output logic                        dout_last,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        overflow
);
  import jpeg_quant_pkg::*;

  localparam int unsigned RW = IN_WIDTH + 1 - FRAC;
  localparam int unsigned IW = $clog2(BLOCK_SIZE);
  localparam logic signed [IN_WIDTH:0] HALF  = (IN_WIDTH+1)'(1) << (FRAC-1);
  localparam logic signed [RW-1:0]     R_MAX = RW'(COEFF_MAX);
  localparam logic signed [RW-1:0]     R_MIN = RW'(COEFF_MIN);

  logic signed [IN_WIDTH:0] din_ext;
  logic signed [IN_WIDTH:0] bias;
  logic signed [IN_WIDTH:0] biased;
  logic signed [RW-1:0]     s1_r;
  logic                     s1_valid;
  qentry_t                  clip;
  qentry_t                  s2_q;
  logic                     s2_valid;
  logic [IW-1:0]            idx;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     wr_en;
  logic                     rd_en;
  qentry_t                  rd_data;

  // One extra bit of headroom so rounding +max up does not wrap.
  always_comb begin
    din_ext = {din[IN_WIDTH-1], din};
    bias    = din[IN_WIDTH-1] ? (HALF - (IN_WIDTH+1)'(1)) : HALF;
    biased  = din_ext + bias;
  end

  always_comb begin
    clip.c   = coeff_t'(s1_r);
    clip.sat = 1'b0;
    if (s1_r > R_MAX) begin
      clip.c   = COEFF_MAX;
      clip.sat = 1'b1;
    end else if (s1_r < R_MIN) begin
      clip.c   = COEFF_MIN;
      clip.sat = 1'b1;
    end
    clip.last = (idx == IW'(BLOCK_SIZE-1));
  end

  assign rd_en = dout_valid & dout_ready;
  assign wr_en = s2_valid & (~fifo_full | rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) s1_r <= RW'(biased >>> FRAC);
      s2_valid <= s1_valid;
      // Index advances for every result, even ones later dropped, so block tags stay aligned.
      if (s1_valid) begin
        s2_q <= clip;
        idx  <= idx + {{(IW-1){1'b0}}, 1'b1};
      end
      if (s2_valid && fifo_full && !rd_en) overflow <= 1'b1;
    end
  end

  quant_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (s2_q),
    .full    (fifo_full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty)
  );

  assign dout_valid = ~fifo_empty;
  assign dout       = rd_data.c;
  assign dout_sat   = rd_data.sat;
  assign dout_last  = rd_data.last;

endmodule

// File: tb/tb_fixed_quant_pack.sv
// Scoreboard bench for fixed_quant_pack: stimulus pushes expected entries, a monitor pops on each handshake.
module tb_fixed_quant_pack;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [51:0] din;
  logic               din_valid;
  logic signed [11:0] dout;
  logic               dout_sat;
  logic               dout_last;
  logic               dout_valid;
  logic               dout_ready;
  logic               overflow;

  typedef struct {
    int c;
    bit sat;
    bit last;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tb_idx  = 0;
  int   pops    = 0;
  int   lasts   = 0;

  always #5 clk = ~clk;

  fixed_quant_pack #(
    .IN_WIDTH   (52),
    .FRAC       (16),
    .OUT_WIDTH  (12),
    .BLOCK_SIZE (64),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_sat   (dout_sat),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && dout_valid && dout_ready) begin
      pops++;
      if (dout_last) lasts++;
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no output", dout);
      end else begin
        e = sbq.pop_front();
        check("dout", dout, e.c);
        check("dout_sat", dout_sat, e.sat);
        check("dout_last", dout_last, e.last);
      end
    end
  end

  task automatic expect_push(input int c, input bit s, input bit drop);
    exp_t e;
    if (!drop) begin
      e.c    = c;
      e.sat  = s;
      e.last = (tb_idx == 63);
      sbq.push_back(e);
    end
    tb_idx = (tb_idx + 1) % 64;
  endtask

  task automatic send(input longint d, input int c, input bit s, input bit drop);
    din       = 52'(d);
    din_valid = 1'b1;
    expect_push(c, s, drop);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_lat(input longint d, input int c);
    din       = 52'(d);
    din_valid = 1'b1;
    expect_push(c, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_T0", dout_valid, 0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    check("latency_T1", dout_valid, 0);
    @(negedge clk);
    check("latency_T2", dout_valid, 0);
    @(negedge clk);
    check("latency_T3", dout_valid, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    sbq.delete();
    tb_idx    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d entries pending, expected 0", name, sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int p0;
    int l0;
    int f;
    int v;

    rst        = 1'b1;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_dout_valid", dout_valid, 0);
    check("reset_overflow", overflow, 0);

    // Rounding, half away from zero, with exact latency
    send_lat(64'sh18000, 2);
    send_lat(-64'sh18000, -2);
    send_lat(64'sh7FFF, 0);
    send_lat(-64'sh8000, -1);

    // Saturation boundaries
    send(longint'(3000) <<< 16, 2047, 1'b1, 1'b0);
    send(-(longint'(3000) <<< 16), -2048, 1'b1, 1'b0);
    send(longint'(2047) <<< 16, 2047, 1'b0, 1'b0);
    send((longint'(1) <<< 51) - 1, 2047, 1'b1, 1'b0);
    send(-(longint'(2048) <<< 16), -2048, 1'b0, 1'b0);
    send(longint'(2048) <<< 16, 2047, 1'b1, 1'b0);
    wait_drain("sat");

    // Block tagging over 130 back-to-back results
    do_reset();
    p0 = pops;
    l0 = lasts;
    for (int i = 0; i < 130; i++) begin
      v = (i * 13) % 2000 - 1000;
      send((longint'(v) <<< 16) + 64'sh4000, v, 1'b0, 1'b0);
    end
    repeat (3) @(negedge clk);
    #1;
    check("block_pops", pops - p0, 130);
    check("block_lasts", lasts - l0, 2);
    wait_drain("block");

    // Full FIFO with simultaneous pop: ready rises as the fifth result reaches the write port
    dout_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) dout_ready = 1'b1;
      v = i * 100 - 600;
      send((longint'(v) <<< 16) + 64'sh8000, (v < 0) ? v : v + 1, 1'b0, 1'b0);
    end
    check("fullpop_overflow", overflow, 0);
    wait_drain("fullpop");
    check("fullpop_overflow_after", overflow, 0);

    // Backpressure and drop; stored results sit at indices 58..61, dropped one at 62
    while (tb_idx != 58) begin
      f = tb_idx * 3 - 50;
      send(longint'(f) <<< 16, f, 1'b0, 1'b0);
    end
    wait_drain("filler");
    dout_ready = 1'b0;
    send(longint'(500) <<< 16, 500, 1'b0, 1'b0);
    send(-(longint'(500) <<< 16), -500, 1'b0, 1'b0);
    send(longint'(1234) <<< 16, 1234, 1'b0, 1'b0);
    send(-(longint'(7) <<< 16), -7, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_full_valid", dout_valid, 1);
    check("bp_full_overflow", overflow, 0);
    check("bp_head_hold", dout, 500);
    send(longint'(777) <<< 16, 777, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_drop_overflow", overflow, 1);
    check("bp_head_hold_after_drop", dout, 500);
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    wait_drain("bp");
    check("bp_overflow_sticky", overflow, 1);
    send(longint'(3) <<< 16, 3, 1'b0, 1'b0);
    send(longint'(4) <<< 16, 4, 1'b0, 1'b0);
    wait_drain("bp_align");
    check("bp_overflow_sticky2", overflow, 1);

    // Mid-operation reset with 3 buffered and 2 in flight
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(longint'(i + 10) <<< 16, i + 10, 1'b0, 1'b0);
    do_reset();
    check("rst_dout_valid", dout_valid, 0);
    check("rst_overflow", overflow, 0);
    repeat (5) @(negedge clk);
    check("rst_inflight_flushed", dout_valid, 0);
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    l0 = lasts;
    for (int i = 0; i < 64; i++) send(longint'(i - 32) <<< 16, i - 32, 1'b0, 1'b0);
    wait_drain("post_reset");
    check("post_reset_lasts", lasts - l0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
